// File: rtl/jt9346_asave_tmr.sv
// rtl/jt9346_asave_tmr.sv - autosave idle timer with single-shot request pulse
// Counts while enabled and dirty; saturates at all-ones after one req pulse.
module jt9346_asave_tmr #(
  parameter int TW = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic flag,
  output logic req
);

  localparam logic [TW-1:0] PRE_MAX = {{(TW-1){1'b1}}, 1'b0};

  logic [TW-1:0] tmr;

  always_ff @(posedge clk) begin
    if (rst || !(en && flag)) begin
      tmr <= '0;
      req <= 1'b0;
    end else begin
      if (tmr != '1) tmr <= tmr + TW'(1);
      // Fires only on the step into saturation, so a held timer never re-fires.
      req <= (tmr == PRE_MAX);
    end
  end

endmodule

// File: rtl/jt9346_dump_ctrl.sv
// rtl/jt9346_dump_ctrl.sv - load/save sequencer for the EEPROM wrapper byte dump port
// Streams a full NVRAM image in or out and raises an autosave request after an idle dirty period.
module jt9346_dump_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 16,
  parameter int RDLAT = 2,
  parameter int TW    = 20,
  localparam int BW   = (DW == 16) ? AW + 1 : AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          ld_start,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          sv_start,
  output logic [7:0]    sv_data,
  output logic          sv_valid,
  input  logic          sv_ready,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          autosave_req,
  output logic [BW:0]   ee_addr,
  output logic          ee_we,
  output logic [7:0]    ee_din,
  input  logic [7:0]    ee_dout,
  input  logic          ee_flag,
  output logic          ee_clr
);

  localparam int NB = 1 << BW;
  localparam int WW = $clog2(RDLAT + 2);
  localparam logic [BW:0]   LAST_BYTE = (BW + 1)'(NB - 1);
  localparam logic [WW-1:0] RD_END    = WW'(RDLAT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SAVE_RD  = 3'd2,
    ST_SAVE_OUT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t        state, nxt;
  logic [BW:0]   cnt;
  logic [WW-1:0] wcnt;
  logic          we_q;
  logic [7:0]    din_q;
  logic [7:0]    sv_q;
  logic          last;
  logic          accept;

  assign last     = (cnt == LAST_BYTE);
  assign ld_ready = (state == ST_LOAD) && !we_q;
  assign accept   = ld_valid && ld_ready && !abort;

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign ee_clr   = (state == ST_DONE);
  assign sv_valid = (state == ST_SAVE_OUT);
  assign sv_data  = sv_q;
  assign ee_we    = we_q;
  assign ee_din   = din_q;
  assign ee_addr  = {1'b0, cnt[BW-1:0]};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (ld_start)      nxt = ST_LOAD;
        else if (sv_start) nxt = ST_SAVE_RD;
      end
      ST_LOAD:     if (we_q && last) nxt = ST_DONE;
      ST_SAVE_RD:  if (wcnt == RD_END) nxt = ST_SAVE_OUT;
      ST_SAVE_OUT: if (sv_ready) nxt = last ? ST_DONE : ST_SAVE_RD;
      ST_DONE:     nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      we_q  <= 1'b0;
      din_q <= '0;
      sv_q  <= '0;
    end else begin
      state <= nxt;
      we_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          wcnt <= '0;
          if (ld_start || sv_start) cnt <= '0;
        end
        ST_LOAD: begin
          // Write strobe lands one cycle after acceptance; address advances after it.
          if (accept) begin
            we_q  <= 1'b1;
            din_q <= ld_data;
          end
          if (we_q) cnt <= cnt + 1'b1;
        end
        ST_SAVE_RD: begin
          if (wcnt == RD_END) begin
            sv_q <= ee_dout;
            wcnt <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_SAVE_OUT: if (sv_ready && !abort) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  jt9346_asave_tmr #(.TW(TW)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_IDLE),
    .flag (ee_flag),
    .req  (autosave_req)
  );

endmodule
